// File: rtl/matrix_scan_ctrl_if.sv
// Bundle between the scan scheduler, matrix_memory and the HUB75 panel pins.
// No latency of its own; pure wiring with directional modports.
// No backpressure: the memory answers within a fixed latency, the panel never stalls.
interface matrix_scan_ctrl_if #(
  parameter int MATRIX_WIDTH    = 64,
  parameter int DATA_WIDTH      = 8,
  parameter int SCAN_VAL_LENGTH = 5
);
  logic                       enable;
  logic [MATRIX_WIDTH-1:0]    pwm_data_ra;
  logic [MATRIX_WIDTH-1:0]    pwm_data_rb;
  logic [MATRIX_WIDTH-1:0]    pwm_data_ga;
  logic [MATRIX_WIDTH-1:0]    pwm_data_gb;
  logic [MATRIX_WIDTH-1:0]    pwm_data_ba;
  logic [MATRIX_WIDTH-1:0]    pwm_data_bb;
  logic [SCAN_VAL_LENGTH-1:0] scan_val;
  logic [DATA_WIDTH-1:0]      current_bcm_bit;
  logic                       panel_r1;
  logic                       panel_g1;
  logic                       panel_b1;
  logic                       panel_r2;
  logic                       panel_g2;
  logic                       panel_b2;
  logic                       panel_clk;
  logic                       panel_lat;
  logic                       panel_oe_n;
  logic [SCAN_VAL_LENGTH-1:0] panel_addr;
  logic                       frame_done;
  logic                       busy;

  // Scheduler side
  modport master (
    input  enable, pwm_data_ra, pwm_data_rb, pwm_data_ga, pwm_data_gb, pwm_data_ba, pwm_data_bb,
    output scan_val, current_bcm_bit,
    output panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2,
    output panel_clk, panel_lat, panel_oe_n, panel_addr, frame_done, busy
  );

  // Memory / panel / control side
  modport slave (
    output enable, pwm_data_ra, pwm_data_rb, pwm_data_ga, pwm_data_gb, pwm_data_ba, pwm_data_bb,
    input  scan_val, current_bcm_bit,
    input  panel_r1, panel_g1, panel_b1, panel_r2, panel_g2, panel_b2,
    input  panel_clk, panel_lat, panel_oe_n, panel_addr, frame_done, busy
  );
endinterface

// File: rtl/matrix_scan_ctrl.sv
// Row / bit-plane scan scheduler with binary code modulation for a HUB75 panel.
// Bit period = MEM_LATENCY + 2*MATRIX_WIDTH + 1 + (BASE_TICKS << bit) clocks.
// No backpressure; enable is only honoured in IDLE and on the last DISPLAY clock.
module matrix_scan_ctrl #(
  parameter int MATRIX_WIDTH    = 64,
  parameter int DATA_WIDTH      = 8,
  parameter int SCAN_VAL_LENGTH = 5,
  parameter int SCAN_ROWS       = 16,
  parameter int BASE_TICKS      = 4,
  parameter int MEM_LATENCY     = 1
) (
  input  logic                clk,
  input  logic                rst,
  matrix_scan_ctrl_if.master  bus
);

  localparam int COL_W = $clog2(MATRIX_WIDTH);
  // Wide enough to hold BASE_TICKS << (DATA_WIDTH-1) without wrapping
  localparam int CNT_W = DATA_WIDTH + $clog2(BASE_TICKS);
  localparam int FET_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] BASE_C = CNT_W'(BASE_TICKS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_SHIFT,
    ST_LATCH,
    ST_DISPLAY
  } state_t;

  state_t                              state_q, state_d;
  logic [SCAN_VAL_LENGTH-1:0]          scan_q, scan_d;
  logic [DATA_WIDTH-1:0]               bit_q, bit_d;
  logic [SCAN_VAL_LENGTH-1:0]          addr_q, addr_d;
  logic [COL_W-1:0]                    col_q, col_d;
  logic                                phase_q, phase_d;
  logic [FET_W-1:0]                    fetch_q, fetch_d;
  logic [CNT_W-1:0]                    disp_q, disp_d;
  // Channel order: 0=ra 1=ga 2=ba 3=rb 4=gb 5=bb
  logic [5:0][MATRIX_WIDTH-1:0]        sr_q, sr_d;
  logic [5:0]                          colour_q, colour_d;

  logic [5:0]                          colour_out;
  logic [CNT_W-1:0]                    disp_len;
  logic                                disp_last;
  logic                                last_bit;
  logic                                last_row;
  logic                                frame_done_c;

  // Current column is always the MSB of each shift register; pins hold their last value elsewhere
  always_comb begin
    colour_out = colour_q;
    if (state_q == ST_SHIFT) begin
      for (int ch = 0; ch < 6; ch++) colour_out[ch] = sr_q[ch][MATRIX_WIDTH-1];
    end
  end

  assign disp_len  = BASE_C << bit_q;
  assign disp_last = (disp_q == disp_len - CNT_W'(1));
  assign last_bit  = (bit_q == DATA_WIDTH'(DATA_WIDTH - 1));
  assign last_row  = (scan_q == SCAN_VAL_LENGTH'(SCAN_ROWS - 1));

  // Next-state and datapath updates for the scan sequence
  always_comb begin
    state_d      = state_q;
    scan_d       = scan_q;
    bit_d        = bit_q;
    addr_d       = addr_q;
    col_d        = col_q;
    phase_d      = phase_q;
    fetch_d      = fetch_q;
    disp_d       = disp_q;
    sr_d         = sr_q;
    colour_d     = colour_q;
    frame_done_c = 1'b0;

    case (state_q)
      ST_IDLE: begin
        scan_d = '0;
        bit_d  = '0;
        if (bus.enable) begin
          state_d = ST_FETCH;
          fetch_d = '0;
        end
      end

      ST_FETCH: begin
        if (fetch_q == FET_W'(MEM_LATENCY - 1)) begin
          sr_d    = {bus.pwm_data_bb, bus.pwm_data_gb, bus.pwm_data_rb,
                     bus.pwm_data_ba, bus.pwm_data_ga, bus.pwm_data_ra};
          state_d = ST_SHIFT;
          col_d   = COL_W'(MATRIX_WIDTH - 1);
          phase_d = 1'b0;
        end else begin
          fetch_d = fetch_q + FET_W'(1);
        end
      end

      ST_SHIFT: begin
        colour_d = colour_out;
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          for (int ch = 0; ch < 6; ch++) sr_d[ch] = {sr_q[ch][MATRIX_WIDTH-2:0], 1'b0};
          if (col_q == '0) begin
            state_d = ST_LATCH;
            addr_d  = scan_q;
          end else begin
            col_d = col_q - COL_W'(1);
          end
        end
      end

      ST_LATCH: begin
        state_d = ST_DISPLAY;
        disp_d  = '0;
      end

      ST_DISPLAY: begin
        if (disp_last) begin
          if (last_bit) begin
            bit_d  = '0;
            scan_d = last_row ? '0 : scan_q + SCAN_VAL_LENGTH'(1);
            frame_done_c = last_row;
          end else begin
            bit_d = bit_q + DATA_WIDTH'(1);
          end
          if (bus.enable) begin
            state_d = ST_FETCH;
            fetch_d = '0;
          end else begin
            state_d = ST_IDLE;
            scan_d  = '0;
            bit_d   = '0;
          end
        end else begin
          disp_d = disp_q + CNT_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared immediately on reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      scan_q   <= '0;
      bit_q    <= '0;
      addr_q   <= '0;
      col_q    <= '0;
      phase_q  <= 1'b0;
      fetch_q  <= '0;
      disp_q   <= '0;
      sr_q     <= '0;
      colour_q <= '0;
    end else begin
      state_q  <= state_d;
      scan_q   <= scan_d;
      bit_q    <= bit_d;
      addr_q   <= addr_d;
      col_q    <= col_d;
      phase_q  <= phase_d;
      fetch_q  <= fetch_d;
      disp_q   <= disp_d;
      sr_q     <= sr_d;
      colour_q <= colour_d;
    end
  end

  assign bus.scan_val        = scan_q;
  assign bus.current_bcm_bit = bit_q;
  assign bus.panel_addr      = addr_q;
  assign {bus.panel_b2, bus.panel_g2, bus.panel_r2,
          bus.panel_b1, bus.panel_g1, bus.panel_r1} = colour_out;
  assign bus.panel_clk  = (state_q == ST_SHIFT) && phase_q;
  assign bus.panel_lat  = (state_q == ST_LATCH);
  assign bus.panel_oe_n = (state_q != ST_DISPLAY);
  assign bus.frame_done = frame_done_c;
  assign bus.busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_matrix_scan_ctrl.sv
// Bench for matrix_scan_ctrl: random frame memory, checks every bit period
// against the scan schedule computed from row/bit and BASE_TICKS << bit.
module tb_matrix_scan_ctrl;
  localparam int MW   = 64;
  localparam int DW   = 8;
  localparam int SVL  = 5;
  localparam int ROWS = 16;
  localparam int BT   = 4;
  localparam int LAT  = 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  matrix_scan_ctrl_if #(.MATRIX_WIDTH(MW), .DATA_WIDTH(DW), .SCAN_VAL_LENGTH(SVL)) bus ();

  matrix_scan_ctrl #(
    .MATRIX_WIDTH(MW), .DATA_WIDTH(DW), .SCAN_VAL_LENGTH(SVL),
    .SCAN_ROWS(ROWS), .BASE_TICKS(BT), .MEM_LATENCY(LAT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Frame memory: [row][bit][channel 0=ra 1=ga 2=ba 3=rb 4=gb 5=bb]
  logic [MW-1:0] mem [ROWS][DW][6];
  int n_chk  = 0;
  int n_pass = 0;
  int fd_count = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [5:0] get_pins();
    return {bus.panel_b2, bus.panel_g2, bus.panel_r2, bus.panel_b1, bus.panel_g1, bus.panel_r1};
  endfunction

  // Memory answers a new address with the right row/plane for one cycle; garbage otherwise
  logic          prev_busy = 1'b0;
  logic [DW-1:0] prev_bit  = '0;
  always @(negedge clk) begin
    logic [MW-1:0] v [6];
    if (bus.busy && (!prev_busy || bus.current_bcm_bit != prev_bit) &&
        int'(bus.scan_val) < ROWS && int'(bus.current_bcm_bit) < DW) begin
      for (int c = 0; c < 6; c++) v[c] = mem[bus.scan_val][bus.current_bcm_bit][c];
    end else begin
      for (int c = 0; c < 6; c++) v[c] = {$urandom(), $urandom()};
    end
    bus.pwm_data_ra = v[0];
    bus.pwm_data_ga = v[1];
    bus.pwm_data_ba = v[2];
    bus.pwm_data_rb = v[3];
    bus.pwm_data_gb = v[4];
    bus.pwm_data_bb = v[5];
    prev_busy = bus.busy;
    prev_bit  = bus.current_bcm_bit;
  end

  always @(negedge clk) if (bus.frame_done === 1'b1) fd_count++;

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  // One bit period starting with the FETCH cycle at the next negedge
  task automatic run_period(input int row, input int b, input int drop_at);
    logic [MW-1:0] exp [6];
    logic [5:0]    want, want0;
    int T, cyc, col, shift_bad, rises, disp_bad, fd_bad;
    logic prev_clk;
    T = BT << b;
    cyc = 0; shift_bad = 0; rises = 0; disp_bad = 0; fd_bad = 0;
    for (int c = 0; c < 6; c++) exp[c] = mem[row][b][c];
    want0 = {exp[5][0], exp[4][0], exp[3][0], exp[2][0], exp[1][0], exp[0][0]};

    @(negedge clk); #1;
    chk($sformatf("fetch_scan r%0d b%0d", row, b), 64'(bus.scan_val), 64'(row));
    chk($sformatf("fetch_bit r%0d b%0d", row, b), 64'(bus.current_bcm_bit), 64'(b));
    chk("fetch_oe_n", 64'(bus.panel_oe_n), 64'd1);
    chk("fetch_busy", 64'(bus.busy), 64'd1);
    prev_clk = bus.panel_clk;

    for (int k = 0; k < MW; k++) begin
      for (int ph = 0; ph < 2; ph++) begin
        @(negedge clk); #1;
        cyc++;
        if (cyc == drop_at) bus.enable = 1'b0;
        col  = MW - 1 - k;
        want = {exp[5][col], exp[4][col], exp[3][col], exp[2][col], exp[1][col], exp[0][col]};
        if (get_pins() !== want || bus.panel_clk !== ph[0] || bus.panel_oe_n !== 1'b1 ||
            bus.panel_lat !== 1'b0 || bus.frame_done !== 1'b0 || bus.busy !== 1'b1)
          shift_bad++;
        if (!prev_clk && bus.panel_clk) rises++;
        prev_clk = bus.panel_clk;
      end
    end
    chk($sformatf("shift_bad r%0d b%0d", row, b), 64'(shift_bad), 64'd0);
    chk("clk_rises", 64'(rises), 64'(MW));

    @(negedge clk); #1;
    chk("latch_lat", 64'(bus.panel_lat), 64'd1);
    chk("latch_oe_n", 64'(bus.panel_oe_n), 64'd1);
    chk("latch_addr", 64'(bus.panel_addr), 64'(row));
    chk("latch_pins_hold", 64'(get_pins()), 64'(want0));

    for (int t = 0; t < T; t++) begin
      @(negedge clk); #1;
      if (bus.panel_oe_n !== 1'b0 || bus.panel_lat !== 1'b0 || bus.panel_clk !== 1'b0 ||
          bus.panel_addr !== SVL'(row) || get_pins() !== want0)
        disp_bad++;
      if (bus.frame_done !== ((t == T - 1) && row == ROWS - 1 && b == DW - 1)) fd_bad++;
    end
    chk($sformatf("display_bad r%0d b%0d", row, b), 64'(disp_bad), 64'd0);
    chk($sformatf("frame_done_bad r%0d b%0d", row, b), 64'(fd_bad), 64'd0);
  endtask

  initial begin
    int bad;
    rst = 1'b0;
    bus.enable = 1'b0;
    for (int r = 0; r < ROWS; r++)
      for (int b = 0; b < DW; b++)
        for (int c = 0; c < 6; c++) mem[r][b][c] = {$urandom(), $urandom()};
    mem[0][0][0] = 64'h8000_0000_0000_0001;
    for (int c = 1; c < 6; c++) mem[0][0][c] = '0;

    #1 rst = 1'b1;
    #1;
    chk("rst_oe_n", 64'(bus.panel_oe_n), 64'd1);
    chk("rst_clk", 64'(bus.panel_clk), 64'd0);
    chk("rst_lat", 64'(bus.panel_lat), 64'd0);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_scan", 64'(bus.scan_val), 64'd0);
    chk("rst_bit", 64'(bus.current_bcm_bit), 64'd0);
    chk("rst_addr", 64'(bus.panel_addr), 64'd0);
    chk("rst_fd", 64'(bus.frame_done), 64'd0);
    chk("rst_pins", 64'(get_pins()), 64'd0);

    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    @(negedge clk); #1;
    chk("idle_busy", 64'(bus.busy), 64'd0);
    chk("idle_oe_n", 64'(bus.panel_oe_n), 64'd1);
    bus.enable = 1'b1;

    // Full frame, then the wrap into the next one
    for (int r = 0; r < ROWS; r++)
      for (int b = 0; b < DW; b++) run_period(r, b, -1);
    chk("frame_done_count", 64'(fd_count), 64'd1);
    run_period(0, 0, -1);
    run_period(0, 1, -1);
    run_period(0, 2, -1);

    // enable dropped during SHIFT: this plane still displays fully, then IDLE
    run_period(0, 3, 20);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (bus.busy !== 1'b0 || bus.panel_oe_n !== 1'b1 || bus.scan_val !== '0 ||
          bus.current_bcm_bit !== '0 || bus.panel_clk !== 1'b0)
        bad++;
    end
    chk("idle_after_drop", 64'(bad), 64'd0);
    chk("frame_done_count2", 64'(fd_count), 64'd1);
    bus.enable = 1'b1;
    run_period(0, 0, -1);

    // Asynchronous reset while panel_clk is high in SHIFT
    @(negedge clk); #1;
    repeat (20) @(negedge clk);
    #1;
    chk("pre_rst_clk_high", 64'(bus.panel_clk), 64'd1);
    chk("pre_rst_bit", 64'(bus.current_bcm_bit), 64'd1);
    rst = 1'b1;
    #1;
    chk("arst_oe_n", 64'(bus.panel_oe_n), 64'd1);
    chk("arst_clk", 64'(bus.panel_clk), 64'd0);
    chk("arst_scan", 64'(bus.scan_val), 64'd0);
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_bit", 64'(bus.current_bcm_bit), 64'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      if (bus.panel_clk !== 1'b0 || bus.panel_lat !== 1'b0 || bus.panel_oe_n !== 1'b1) bad++;
    end
    chk("arst_no_pulses", 64'(bad), 64'd0);
    rst = 1'b0;
    run_period(0, 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
